tile_ram_arbiter: RTL and testbench
===================================

// Module: tile_ram_arbiter
// PURPOSE
//  Arbitrates one single-port, synchronous-read tile/sprite RAM between two requesters:
//  - the video fetch path, which is pixel-rate and hard real-time;
//  - the game-logic path, which handles ball/Mario updates and level edits.
//  Sits between vga_controller/ball and the on-chip RAM in the top level.
//  Video has absolute priority; logic uses spare cycles via a req/ack handshake.
// PARAMETERS
//  ADDR_W    11    RAM address width (2048 entries)
//  DATA_W    8     RAM word width (tile/palette index)
//  WAIT_MAX  1023  logic wait cycles before log_starve sets
//  CNT_W     16    width of stats counter (ARB_STATS_EN only)
// PORTS
//  Clk         in   1       system clock (MAX10_CLK1_50 domain)
//  Reset_n     in   1       asynchronous, active-low reset
//  vid_req     in   1       video read strobe, one cycle per fetch
//  vid_addr    in   ADDR_W  video read address
//  vid_rvalid  out  1       video read data valid
//  vid_rdata   out  DATA_W  video read data
//  log_req     in   1       logic request, held until log_ack
//  log_we      in   1       1=write, 0=read; stable while log_req=1
//  log_addr    in   ADDR_W  logic address; stable while log_req=1
//  log_wdata   in   DATA_W  logic write data; stable while log_req=1
//  log_ack     out  1       one-cycle pulse: logic request accepted
//  log_rvalid  out  1       logic read data valid
//  log_rdata   out  DATA_W  logic read data
//  log_starve  out  1       sticky: a logic wait reached WAIT_MAX
//  ram_addr    out  ADDR_W  RAM address (registered)
//  ram_we      out  1       RAM write enable (registered)
//  ram_wdata   out  DATA_W  RAM write data (registered)
//  ram_rdata   in   DATA_W  RAM read data, valid one cycle after addressed
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0; FSM=S_IDLE; wait counter 0; pipeline tags cleared.
//  - Grant each cycle:
//    - vid_req=1: video owns RAM. ram_addr<=vid_addr, ram_we<=0.
//    - else, if log_req=1 and FSM=S_IDLE: logic owns RAM. ram_addr/ram_we/ram_wdata <= log_*.
//    - else: ram_we<=0; ram_addr holds.
//  - FSM:
//    - S_IDLE -> S_ACK on a logic grant.
//    - S_ACK -> S_IDLE unconditionally.
//    - log_ack=1 exactly while in S_ACK.
//    - log_req is ignored in S_ACK, so there are never back-to-back logic grants and no double grant.
//  - Latency:
//    - Request to registered RAM address: 1 cycle.
//    - Request to vid_rvalid/log_rvalid: 2 cycles.
//    - rdata = ram_rdata gated by a 2-stage {valid, owner} tag pipeline.
//    - Writes produce no rvalid. A write is committed in the log_ack cycle.
//  - Video is never stalled. vid_req every cycle starves logic indefinitely; this is legal.
//  - Wait counter:
//    - Counts cycles with log_req=1 and no grant; clears on grant.
//    - Saturates at WAIT_MAX, then sets log_starve.
//    - log_starve clears only on reset.
//  - A log_req drop before ack is legal: request withdrawn, counter clears.
//  - vid_rvalid and log_rvalid are never high in the same cycle.
//  - Reset mid-operation: in-flight tags flushed; no rvalid/ack after reset release until new requests.
// CONFIGURATION
//  - ARB_STATS_EN defined:
//    - Adds output conflict_cnt [CNT_W-1:0].
//    - Increments on each cycle with vid_req=1 and log_req=1 in S_IDLE.
//    - Saturates at all-ones; reset to 0.
//  - ARB_STATS_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Video read only:
//     - Stimulus: vid_req pulse, addr=0x010, RAM[0x010]=0x5A.
//     - Response: 2 cycles later vid_rvalid=1, vid_rdata=0x5A; log_ack stays 0.
//  2. Logic write then read:
//     - Stimulus: write 0x3C to 0x7FF, then read 0x7FF.
//     - Response: log_ack pulse per request; read rvalid 2 cycles after its grant, log_rdata=0x3C.
//  3. Collision:
//     - Stimulus: vid_req and log_req(read 0x001) rise together; vid_req alternates 1,0.
//     - Response: video granted first; logic granted in the next idle cycle; no double ack.
//  4. Starvation:
//     - Stimulus: vid_req=1 continuously, log_req=1 for 1030 cycles (WAIT_MAX=1023).
//     - Response: log_starve=1 from cycle 1024 on; still 1 after vid_req drops and logic is granted.
//  5. Reset mid-operation:
//     - Stimulus: assert Reset_n=0 one cycle after a video grant.
//     - Response: all outputs 0 immediately; no vid_rvalid after release.
//  6. ARB_STATS_EN: 5 collision cycles -> conflict_cnt=5; counter absent when undefined.

Source files
------------

// File: rtl/tile_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tile_ram_arbiter
//
// Shares one single-port, synchronous-read tile/sprite RAM between the
// pixel-rate video fetch path and the game-logic path. Video always wins;
// logic is served in spare cycles through a req/ack handshake.
//
// Handshake (logic side): the requester raises log_req with log_we, log_addr
// and log_wdata stable, and holds them until it sees the one-cycle log_ack
// pulse. A request is granted in a cycle where vid_req=0 and the arbiter is
// idle; log_ack follows in the next cycle. Dropping log_req before log_ack
// withdraws the request. The video side has no handshake: a vid_req strobe
// is always accepted in the cycle it is presented.
//
// Timing: request cycle N -> registered RAM address in N+1 -> read data and
// rvalid in N+2. Writes are committed (ram_we=1) in the log_ack cycle and
// produce no rvalid.
//
// Ports:
//   Clk, Reset_n                 clock, asynchronous active-low reset
//   vid_req, vid_addr            video read strobe and address
//   vid_rvalid, vid_rdata        video read return
//   log_req, log_we, log_addr,
//   log_wdata                    logic request
//   log_ack                      one-cycle acceptance pulse
//   log_rvalid, log_rdata        logic read return
//   log_starve                   sticky: a logic wait reached WAIT_MAX
//   ram_addr, ram_we, ram_wdata  registered RAM command
//   ram_rdata                    RAM read data (one cycle after address)
//   conflict_cnt                 collision counter (ARB_STATS_EN only)
//
// Configuration macro: ARB_STATS_EN adds the CNT_W parameter and the
// conflict_cnt output, counting cycles where video and logic request
// together while idle (saturating).
// ---------------------------------------------------------------------------
module tile_ram_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int WAIT_MAX = 1023
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              log_req,
    input  logic              log_we,
    input  logic [ADDR_W-1:0] log_addr,
    input  logic [DATA_W-1:0] log_wdata,
    output logic              log_ack,
    output logic              log_rvalid,
    output logic [DATA_W-1:0] log_rdata,
    output logic              log_starve,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  conflict_cnt
`endif
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_log_ack;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_we;
    logic [DATA_W-1:0]   r_ram_wdata;
    // Read tag pipeline: stage 1 lines up with the registered address,
    // stage 2 with the RAM data coming back.
    logic                r_tag1_valid;
    logic                r_tag1_vid;
    logic                r_tag2_valid;
    logic                r_tag2_vid;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_starve;

    logic                w_vid_grant;
    logic                w_log_grant;
    logic                w_log_wait;

    // Logic is only considered while idle, so the ack cycle can never
    // produce a second grant.
    assign w_vid_grant = vid_req;
    assign w_log_grant = !vid_req && log_req && (r_state == S_IDLE);
    assign w_log_wait  = log_req && !w_log_grant && (r_state == S_IDLE);

    // FSM with registered ack.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_log_ack <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_log_grant) begin
                        r_state   <= S_ACK;
                        r_log_ack <= 1'b1;
                    end else begin
                        r_log_ack <= 1'b0;
                    end
                end
                S_ACK: begin
                    r_state   <= S_IDLE;
                    r_log_ack <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_log_ack <= 1'b0;
                end
            endcase
        end
    end

    // RAM command register and read tag pipeline.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_ram_wdata  <= '0;
            r_tag1_valid <= 1'b0;
            r_tag1_vid   <= 1'b0;
            r_tag2_valid <= 1'b0;
            r_tag2_vid   <= 1'b0;
        end else begin
            if (w_vid_grant) begin
                r_ram_addr   <= vid_addr;
                r_ram_we     <= 1'b0;
                r_tag1_valid <= 1'b1;
                r_tag1_vid   <= 1'b1;
            end else if (w_log_grant) begin
                r_ram_addr   <= log_addr;
                r_ram_we     <= log_we;
                r_ram_wdata  <= log_wdata;
                r_tag1_valid <= !log_we;
                r_tag1_vid   <= 1'b0;
            end else begin
                r_ram_we     <= 1'b0;
                r_tag1_valid <= 1'b0;
                r_tag1_vid   <= 1'b0;
            end
            r_tag2_valid <= r_tag1_valid;
            r_tag2_vid   <= r_tag1_vid;
        end
    end

    // Wait counter and sticky starvation flag. The flag latches once the
    // counter has sat at its limit for a cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wait   <= '0;
            r_starve <= 1'b0;
        end else begin
            if (w_log_wait) begin
                if (r_wait != WAIT_LIM) begin
                    r_wait <= r_wait + WAIT_W'(1);
                end
            end else begin
                r_wait <= '0;
            end
            if (r_wait == WAIT_LIM) begin
                r_starve <= 1'b1;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] r_conflict_cnt;
    logic             w_conflict;

    assign w_conflict = vid_req && log_req && (r_state == S_IDLE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

    // Read returns: RAM data is passed through only when the tag says so,
    // which also forces zeros while the pipeline is flushed by reset.
    assign vid_rvalid = r_tag2_valid && r_tag2_vid;
    assign log_rvalid = r_tag2_valid && !r_tag2_vid;
    assign vid_rdata  = vid_rvalid ? ram_rdata : '0;
    assign log_rdata  = log_rvalid ? ram_rdata : '0;

    assign log_ack    = r_log_ack;
    assign log_starve = r_starve;
    assign ram_addr   = r_ram_addr;
    assign ram_we     = r_ram_we;
    assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tile_ram_arbiter
//
// Drives tile_ram_arbiter against a behavioural RAM and compares every cycle
// with a transaction-level reference: grants are decided from the priority
// rules, read data comes from a golden memory updated in grant order, and
// returns are scheduled two cycles after their grant.
// ---------------------------------------------------------------------------
module tb_tile_ram_arbiter;

    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 8;
    localparam int WAIT_MAX = 1023;
    localparam int CNT_W    = 16;
    localparam int DEPTH    = 1 << ADDR_W;

    // ---------------- clock / reset ----------------
    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    logic              vid_req = 1'b0;
    logic [ADDR_W-1:0] vid_addr = '0;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              log_req = 1'b0;
    logic              log_we = 1'b0;
    logic [ADDR_W-1:0] log_addr = '0;
    logic [DATA_W-1:0] log_wdata = '0;
    logic              log_ack;
    logic              log_rvalid;
    logic [DATA_W-1:0] log_rdata;
    logic              log_starve;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;
`ifdef ARB_STATS_EN
    logic [CNT_W-1:0]  conflict_cnt;
`endif

    tile_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)
`ifdef ARB_STATS_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .log_req(log_req), .log_we(log_we), .log_addr(log_addr),
        .log_wdata(log_wdata), .log_ack(log_ack),
        .log_rvalid(log_rvalid), .log_rdata(log_rdata),
        .log_starve(log_starve),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
`ifdef ARB_STATS_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    // ---------------- behavioural RAM ----------------
    // Unwritten locations return a fixed address pattern (0x010 -> 0x5A).
    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ {a[10:8], 5'b0} ^ 8'h4A;
    endfunction

    logic [DATA_W-1:0] mem    [DEPTH];
    logic              mem_ok [DEPTH];
    always @(posedge Clk) begin
        if (ram_we) begin
            mem[ram_addr]    <= ram_wdata;
            mem_ok[ram_addr] <= 1'b1;
        end
        ram_rdata <= (mem_ok[ram_addr] === 1'b1) ? mem[ram_addr] : pat(ram_addr);
    end

    // ---------------- scoreboard / reference ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DATA_W-1:0] gold [DEPTH];
    logic [DATA_W-1:0] vid_exp_q[$];
    int                vid_due_q[$];
    logic [DATA_W-1:0] log_exp_q[$];
    int                log_due_q[$];

    bit                m_ack;
    bit                m_starve;
    int                m_streak;
    int                m_conflicts;
    logic [ADDR_W-1:0] m_addr;
    bit                m_we;
    logic [DATA_W-1:0] m_wdata;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        vid_exp_q.delete(); vid_due_q.delete();
        log_exp_q.delete(); log_due_q.delete();
        m_ack = 0; m_starve = 0; m_streak = 0; m_conflicts = 0;
        m_addr = '0; m_we = 0; m_wdata = '0;
        cyc = 0;
    endtask

    task automatic check_outputs();
        bit                ev, el;
        logic [DATA_W-1:0] ed, ld;
        ev = 0; ed = '0; el = 0; ld = '0;
        if (vid_due_q.size() > 0 && vid_due_q[0] == cyc) begin
            ev = 1; ed = vid_exp_q.pop_front(); void'(vid_due_q.pop_front());
        end
        if (log_due_q.size() > 0 && log_due_q[0] == cyc) begin
            el = 1; ld = log_exp_q.pop_front(); void'(log_due_q.pop_front());
        end
        check_eq("vid_rvalid", 32'(vid_rvalid), 32'(ev));
        check_eq("vid_rdata",  32'(vid_rdata),  32'(ed));
        check_eq("log_rvalid", 32'(log_rvalid), 32'(el));
        check_eq("log_rdata",  32'(log_rdata),  32'(ld));
        check_eq("log_ack",    32'(log_ack),    32'(m_ack));
        check_eq("log_starve", 32'(log_starve), 32'(m_starve));
        check_eq("ram_addr",   32'(ram_addr),   32'(m_addr));
        check_eq("ram_we",     32'(ram_we),     32'(m_we));
        check_eq("ram_wdata",  32'(ram_wdata),  32'(m_wdata));
`ifdef ARB_STATS_EN
        check_eq("conflict_cnt", 32'(conflict_cnt), 32'(m_conflicts));
`endif
    endtask

    // One cycle: check this cycle's outputs, present inputs, advance the
    // reference by the arbitration rules, move to the next cycle.
    task automatic step(input bit v, input logic [ADDR_W-1:0] va, input bit l,
                        input bit we, input logic [ADDR_W-1:0] la,
                        input logic [DATA_W-1:0] wd);
        bit lg;
        check_outputs();
        vid_req = v; vid_addr = va;
        log_req = l; log_we = we; log_addr = la; log_wdata = wd;

        lg = !v && l && !m_ack;
        if (m_streak == WAIT_MAX) m_starve = 1;
        if (l && !lg && !m_ack) m_streak = (m_streak < WAIT_MAX) ? m_streak + 1 : WAIT_MAX;
        else m_streak = 0;
        if (v && l && !m_ack && m_conflicts < (1 << CNT_W) - 1) m_conflicts++;

        if (v) begin
            vid_exp_q.push_back(gold[va]); vid_due_q.push_back(cyc + 2);
            m_addr = va; m_we = 0;
        end else if (lg) begin
            m_addr = la; m_we = we; m_wdata = wd;
            if (we) gold[la] = wd;
            else begin
                log_exp_q.push_back(gold[la]); log_due_q.push_back(cyc + 2);
            end
        end else begin
            m_we = 0;
        end
        m_ack = lg;

        @(negedge Clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_vid_rvalid"}, 32'(vid_rvalid), 32'd0);
        check_eq({tag, "_log_rvalid"}, 32'(log_rvalid), 32'd0);
        check_eq({tag, "_log_ack"},    32'(log_ack),    32'd0);
        check_eq({tag, "_log_starve"}, 32'(log_starve), 32'd0);
        check_eq({tag, "_ram_addr"},   32'(ram_addr),   32'd0);
        check_eq({tag, "_ram_we"},     32'(ram_we),     32'd0);
        check_eq({tag, "_ram_wdata"},  32'(ram_wdata),  32'd0);
        check_eq({tag, "_vid_rdata"},  32'(vid_rdata),  32'd0);
    endtask

    // Called at a falling edge; asserts reset mid-cycle and releases it on
    // a later falling edge, away from the active clock edge.
    task automatic apply_reset();
        Reset_n = 1'b0;
        vid_req = 0; log_req = 0; log_we = 0;
        #1;
        check_all_zero("reset");
        model_clear();
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        cyc = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit                pend, p_we;
        logic [ADDR_W-1:0] p_addr;
        logic [DATA_W-1:0] p_wd;
        int                vid_pct;

        for (int i = 0; i < DEPTH; i++) gold[i] = pat(ADDR_W'(i));
        model_clear();
        @(negedge Clk);
        apply_reset();

        // Video read only
        step(1, 11'h010, 0, 0, '0, '0);
        idle(4);

        // Logic write 0x3C to 0x7FF, then read it back
        step(0, '0, 1, 1, 11'h7FF, 8'h3C);
        step(0, '0, 0, 0, '0, '0);
        step(0, '0, 1, 0, 11'h7FF, 8'h00);
        step(0, '0, 0, 0, '0, '0);
        idle(3);

        // Collision: video wins, logic takes the next idle cycle
        step(1, 11'h020, 1, 0, 11'h001, '0);
        step(0, '0,      1, 0, 11'h001, '0);
        step(1, 11'h021, 0, 0, '0, '0);
        step(0, '0,      0, 0, '0, '0);
        idle(3);

        // Randomised traffic with a held-until-ack logic requester
        pend = 0; p_we = 0; p_addr = '0; p_wd = '0; vid_pct = 50;
        for (int i = 0; i < 2000; i++) begin
            bit v;
            if (i % 100 == 0) vid_pct = $urandom_range(0, 95);
            if (m_ack) pend = 0;
            if (!pend && $urandom_range(0, 99) < 40) begin
                pend   = 1;
                p_we   = 1'($urandom_range(0, 1));
                p_addr = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 15))
                                                     : ADDR_W'($urandom_range(0, DEPTH - 1));
                p_wd   = DATA_W'($urandom_range(0, 255));
            end else if (pend && !m_ack && $urandom_range(0, 99) < 3) begin
                pend = 0;
            end
            v = ($urandom_range(0, 99) < vid_pct);
            step(v, ADDR_W'($urandom_range(0, DEPTH - 1)), pend, p_we, p_addr, p_wd);
        end
        idle(4);

        // Reset one cycle after a video grant: tags flushed
        step(1, 11'h055, 0, 0, '0, '0);
        apply_reset();
        idle(5);

        // Five collision cycles, then logic gets in
        for (int i = 0; i < 5; i++) step(1, ADDR_W'(i), 1, 0, 11'h002, '0);
`ifdef ARB_STATS_EN
        check_eq("stats_conflicts5", 32'(conflict_cnt), 32'd5);
`endif
        step(0, '0, 1, 0, 11'h002, '0);
        step(0, '0, 0, 0, '0, '0);
        idle(3);

        // Starvation under continuous video
        for (int i = 0; i < 1030; i++) begin
            if (i == 1023) check_eq("starve_before", 32'(log_starve), 32'd0);
            if (i == 1024) check_eq("starve_set",    32'(log_starve), 32'd1);
            step(1, ADDR_W'(i), 1, 0, 11'h123, '0);
        end
        step(0, '0, 1, 0, 11'h123, '0);
        check_eq("starve_grant_ack", 32'(log_ack), 32'd1);
        step(0, '0, 0, 0, '0, '0);
        idle(3);
        check_eq("starve_sticky", 32'(log_starve), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
